// File: rtl/sseg_scan_ctrl_if.sv
// Bundle of the scan controller's data/handshake signals between the BCD logic and the digit mux.
// The master modport is the producer side; the slave modport belongs to sseg_scan_ctrl.
interface sseg_scan_ctrl_if;
  logic        scan_en;
  logic        load;
  logic [15:0] bcd_in;
  logic        load_ack;
  logic [15:0] bcd_out;
  logic [3:0]  anode;
  logic        mux_en;
  logic        digit_tick;

  modport master (
    output scan_en,
    output load,
    output bcd_in,
    input  load_ack,
    input  bcd_out,
    input  anode,
    input  mux_en,
    input  digit_tick
  );

  modport slave (
    input  scan_en,
    input  load,
    input  bcd_in,
    output load_ack,
    output bcd_out,
    output anode,
    output mux_en,
    output digit_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller with a frame-boundary shadow register for the shown BCD value.
// Optional SSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits; all outputs are registered.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         reset,
  sseg_scan_ctrl_if.slave bus
);

  localparam int            PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q,   state_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [1:0]    idx_q,     idx_d;
  logic [15:0]   shadow_q,  shadow_d;
  logic          pending_q, pending_d;
  logic [15:0]   bcd_out_q, bcd_out_d;
  logic [3:0]    anode_q,   anode_d;
  logic          mux_en_q,  mux_en_d;
  logic          tick_q,    tick_d;
  logic          ack_q,     ack_d;

  logic          commit;
  logic          visible;
  logic          want_commit;
  logic [15:0]   commit_val;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  function automatic logic leading_zero(input logic [1:0] idx, input logic [15:0] val);
    logic z;
    z = 1'b0;
    case (idx)
      2'd3:    z = (val[15:12] == 4'h0);
      2'd2:    z = (val[15:8]  == 8'h00);
      2'd1:    z = (val[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  // A load in the commit cycle wins over an older shadow value.
  assign want_commit = bus.load | pending_q;
  assign commit_val  = bus.load ? bus.bcd_in : shadow_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    mux_en_d = 1'b0;
    visible  = 1'b0;
    commit   = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        idx_d   = 2'd3;
        commit  = want_commit;
        if (bus.scan_en) begin
          state_d  = SCAN;
          mux_en_d = 1'b1;
          visible  = 1'b1;
        end
      end
      SCAN: begin
        if (!bus.scan_en) begin
          state_d = IDLE;
          presc_d = '0;
          idx_d   = 2'd3;
        end else begin
          mux_en_d = 1'b1;
          visible  = 1'b1;
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q - 2'd1;
            tick_d  = 1'b1;
            // Wrapping from digit 0 back to 3 is the frame boundary.
            commit  = (idx_q == 2'd0) && want_commit;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        idx_d   = 2'd3;
      end
    endcase
  end

  always_comb begin
    shadow_d  = bus.load ? bus.bcd_in : shadow_q;
    pending_d = commit ? 1'b0 : (pending_q | bus.load);
    bcd_out_d = commit ? commit_val : bcd_out_q;
    ack_d     = commit;
    anode_d   = visible ? (4'b0001 << idx_d) : 4'b0000;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (leading_zero(idx_d, bcd_out_d)) begin
      anode_d = 4'b0000;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      idx_q     <= 2'd3;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      bcd_out_q <= 16'h0000;
      anode_q   <= 4'b0000;
      mux_en_q  <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bcd_out_q <= bcd_out_d;
      anode_q   <= anode_d;
      mux_en_q  <= mux_en_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.load_ack   = ack_q;
  assign bus.bcd_out    = bcd_out_q;
  assign bus.anode      = anode_q;
  assign bus.mux_en     = mux_en_q;
  assign bus.digit_tick = tick_q;

endmodule
